// File: rtl/bp_table_clear_ctrl.sv
// bp_table_clear_ctrl: sweeps the branch predictor tables invalid after reset and on flush,
// and otherwise hands the RAM write ports to execution-stage predictor updates.
module bp_table_clear_ctrl #(
  parameter  int ENTRIES = 512,
  parameter  int WAYS    = 2,
  parameter  int ENTRY_W = 40,
  localparam int ADDR_W  = $clog2(ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_req,
  output logic                     flush_ack,
  output logic                     busy,
  output logic                     predict_en,
  input  logic                     upd_valid,
  input  logic [WAYS-1:0]          upd_way,
  input  logic [WAYS*ADDR_W-1:0]   upd_addr,
  input  logic [ENTRY_W-1:0]       upd_data,
  output logic                     upd_dropped,
  output logic [WAYS-1:0]          ram_we,
  output logic [WAYS*ADDR_W-1:0]   ram_addr,
  output logic [ENTRY_W-1:0]       ram_wdata
);
  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_IDLE  = 2'd2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ENTRIES - 1);
  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              clearing;
  logic              idle;
  logic              sweep_done;
  assign clearing   = state == S_CLEAR;
  assign idle       = state == S_IDLE;
  // a flush on the last sweep cycle restarts the sweep, so it must not count as completion
  assign sweep_done = clearing && cnt == LAST && !flush_req;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      flush_ack <= 1'b0;
    end else begin
      flush_ack <= sweep_done;
      if ((!clearing && !idle) || (flush_req && (clearing || idle))) begin
        state <= S_CLEAR;
        cnt   <= '0;
      end else if (sweep_done) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (clearing)
        cnt <= cnt + ADDR_W'(1);
    end
  assign busy        = !idle;
  assign predict_en  = idle;
  assign upd_dropped = upd_valid && busy;
  assign ram_we      = clearing ? {WAYS{1'b1}} : idle ? (upd_way & {WAYS{upd_valid}}) : '0;
  assign ram_addr    = clearing ? {WAYS{cnt}} : upd_addr;
  assign ram_wdata   = clearing ? '0 : upd_data;
endmodule

// File: tb/tb_bp_table_clear_ctrl.sv
// tb_bp_table_clear_ctrl: vector table plus scoreboard queue checking the sweep/arbiter
// with ENTRIES=8, WAYS=2; a few hand-written sequences cover restart and async reset.
module tb_bp_table_clear_ctrl;
  typedef struct {
    logic        flush;
    logic        uv;
    logic [1:0]  way;
    logic [5:0]  addr;
    logic [39:0] data;
    logic        ack;
    logic        busy;
    logic        pe;
    logic        drop;
    logic [1:0]  we;
    logic [5:0]  raddr;
    logic [39:0] wdata;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req, flush_ack, busy, predict_en, upd_valid, upd_dropped;
  logic [1:0]  upd_way, ram_we;
  logic [5:0]  upd_addr, ram_addr;
  logic [39:0] upd_data, ram_wdata;
  int          checks = 0;
  int          errors = 0;
  vec_t        sb[$];
  vec_t        tbl[$];
  vec_t        e;
  vec_t        v;
  bp_table_clear_ctrl #(.ENTRIES(8), .WAYS(2), .ENTRY_W(40)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_ack(flush_ack), .busy(busy),
    .predict_en(predict_en), .upd_valid(upd_valid), .upd_way(upd_way), .upd_addr(upd_addr),
    .upd_data(upd_data), .upd_dropped(upd_dropped), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask
  function automatic vec_t vi();
    vec_t r;
    r = '{default: 0};
    r.busy = 1'b1;
    return r;
  endfunction
  function automatic vec_t vc(input int a);
    vec_t r;
    r = vi();
    r.we = 2'b11;
    r.raddr = {a[2:0], a[2:0]};
    return r;
  endfunction
  function automatic vec_t vd(input logic ack);
    vec_t r;
    r = '{default: 0};
    r.pe = 1'b1;
    r.ack = ack;
    return r;
  endfunction
  task automatic drive(input vec_t d);
    flush_req = d.flush;
    upd_valid = d.uv;
    upd_way   = d.way;
    upd_addr  = d.addr;
    upd_data  = d.data;
    sb.push_back(d);
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input int from, input int to);
    for (int a = from; a <= to; a++) drive(vc(a));
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("flush_ack", 64'(flush_ack), 64'(e.ack));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("predict_en", 64'(predict_en), 64'(e.pe));
      chk("upd_dropped", 64'(upd_dropped), 64'(e.drop));
      chk("ram_we", 64'(ram_we), 64'(e.we));
      if (e.we != 2'b00) begin
        chk("ram_addr", 64'(ram_addr), 64'(e.raddr));
        chk("ram_wdata", 64'(ram_wdata), 64'(e.wdata));
      end
    end
  initial begin
    rst = 1'b0;
    flush_req = 1'b0;
    upd_valid = 1'b0;
    upd_way = '0;
    upd_addr = '0;
    upd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    drive(vi());
    rst = 1'b1;
    tbl.push_back(vi());
    for (int a = 0; a < 8; a++) tbl.push_back(vc(a));
    tbl.push_back(vd(1'b1));
    tbl.push_back(vd(1'b0));
    v = vd(1'b0);
    v.uv = 1'b1; v.way = 2'b10; v.addr = {3'd5, 3'd2}; v.data = 40'h80_0000_0123;
    v.we = 2'b10; v.raddr = {3'd5, 3'd2}; v.wdata = 40'h80_0000_0123;
    tbl.push_back(v);
    v = vd(1'b0);
    v.flush = 1'b1; v.uv = 1'b1; v.way = 2'b01; v.addr = {3'd1, 3'd6}; v.data = 40'h80_0000_0abc;
    v.we = 2'b01; v.raddr = {3'd1, 3'd6}; v.wdata = 40'h80_0000_0abc;
    tbl.push_back(v);
    for (int a = 0; a < 8; a++) tbl.push_back(vc(a));
    tbl.push_back(vd(1'b1));
    tbl.push_back(vd(1'b0));
    foreach (tbl[i]) drive(tbl[i]);
    v = vd(1'b0); v.flush = 1'b1; drive(v);
    sweep(0, 4);
    v = vc(5); v.flush = 1'b1; drive(v);
    sweep(0, 7);
    drive(vd(1'b1));
    drive(vd(1'b0));
    drive(vd(1'b0));
    v = vd(1'b0); v.flush = 1'b1; drive(v);
    sweep(0, 1);
    v = vc(2);
    v.uv = 1'b1; v.way = 2'b11; v.addr = 6'h3f; v.data = 40'hff_ffff_ffff; v.drop = 1'b1;
    drive(v);
    sweep(3, 6);
    v = vc(7); v.flush = 1'b1; drive(v);
    sweep(0, 7);
    drive(vd(1'b1));
    v = vd(1'b0); v.flush = 1'b1; drive(v);
    sweep(0, 2);
    rst = 1'b0;
    #1;
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_predict_en", 64'(predict_en), 64'd0);
    chk("rst_flush_ack", 64'(flush_ack), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    v = vi();
    v.flush = 1'b1; v.uv = 1'b1; v.way = 2'b11; v.addr = 6'h2a; v.data = 40'h12_3456_789a; v.drop = 1'b1;
    drive(v);
    sweep(0, 7);
    drive(vd(1'b1));
    drive(vd(1'b0));
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
